mem_bank_ctrl: RTL and testbench

//   Multi-bank, byte-strobed SRAM-style store with independent valid/ready write and read

---
 rtl/mem_bank_pkg.sv | 34 +++
 rtl/mem_rsp_fifo.sv | 49 ++++
 rtl/mem_bank_ctrl.sv | 121 ++++++++++++
 tb/tb_mem_bank_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bank_pkg.sv
// rtl/mem_bank_pkg.sv - shared widths, request types and priority enum for mem_bank_ctrl
package mem_bank_pkg;

  // Default geometry: 128-byte rows, 4 KiB total, two interleaved banks.
  localparam int MEM_SIZE      = 7;
  localparam int MEM_ADDR_W    = 12;
  localparam int MEM_NUM_BANKS = 2;

  // Bank-select width; kept at least 1 so a single-bank build still has a legal vector.
  function automatic int bank_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

  // Rows held by each bank, as an index width.
  function automatic int row_w(input int addr_w, input int size, input int num_banks);
    return addr_w - size - $clog2(num_banks);
  endfunction

  typedef logic [(2**MEM_SIZE)-1:0][7:0] row_data_t;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0]     addr;
    row_data_t                 data;
    logic [(2**MEM_SIZE)-1:0]  strb;
  } wr_req_t;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
  } rd_req_t;

  // Which channel wins the next same-bank collision.
  typedef enum logic {PRIO_WR = 1'b0, PRIO_RD = 1'b1} prio_e;

endpackage

// File: rtl/mem_rsp_fifo.sv
// rtl/mem_rsp_fifo.sv - two-entry read-response buffer carrying row data plus error flag
module mem_rsp_fifo #(
  parameter int DW = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_tvalid,
  output logic          s_tready,
  input  logic [DW-1:0] s_tdata,
  input  logic          s_tuser,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic [DW-1:0] m_tdata,
  output logic          m_tuser
);

  // Entry layout: {err, data}.
  logic [DW:0] ent [2];
  logic        wp, rp;
  logic [1:0]  cnt;
  logic        push, pop;

  // No pass-through when full: the producer only issues against a free slot.
  assign s_tready = (cnt != 2'd2);
  assign m_tvalid = (cnt != 2'd0);
  assign m_tdata  = ent[rp][DW-1:0];
  assign m_tuser  = ent[rp][DW];
  assign push     = s_tvalid & s_tready;
  assign pop      = m_tvalid & m_tready;

  // Pointer and occupancy tracking; reset empties the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) wp <= ~wp;
      if (pop)  rp <= ~rp;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  // Entry storage needs no reset; occupancy decides what is visible.
  always_ff @(posedge clk) begin
    if (push) ent[wp] <= {s_tuser, s_tdata};
  end

endmodule

// File: rtl/mem_bank_ctrl.sv
// rtl/mem_bank_ctrl.sv - banked byte-strobed row store with arbitrated wr/rd and buffered responses; MEM_BANK_PARITY_EN adds per-byte parity
module mem_bank_ctrl
  import mem_bank_pkg::*;
#(
  parameter int SIZE      = MEM_SIZE,
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int NUM_BANKS = MEM_NUM_BANKS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [(2**SIZE)*8-1:0]  wr_data,
  input  logic [(2**SIZE)-1:0]    wr_strb,
  input  logic                    rd_valid,
  output logic                    rd_ready,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [(2**SIZE)*8-1:0]  rsp_data,
  output logic                    rsp_err
);

  localparam int NB     = 2**SIZE;
  localparam int DW     = NB * 8;
  localparam int BANK_S = $clog2(NUM_BANKS);
  localparam int BW     = bank_w(NUM_BANKS);
  localparam int RW     = row_w(ADDR_W, SIZE, NUM_BANKS);
  localparam int ROWS   = 2**RW;

  logic [BW-1:0]  wr_bank, rd_bank;
  logic [RW-1:0]  wr_row, rd_row;
  logic           conflict, credit, wr_fire, rd_fire;
  logic           rd_rerr, fifo_err;
  logic [DW-1:0]  rd_rdata;
  logic [DW-1:0]  bank_rdata [NUM_BANKS];
  logic [NUM_BANKS-1:0] bank_rerr;
  prio_e          prio;

  // Rows interleave across banks: the bits just above the in-row offset pick the bank.
  assign wr_bank = (NUM_BANKS > 1) ? BW'(wr_addr >> SIZE) : '0;
  assign rd_bank = (NUM_BANKS > 1) ? BW'(rd_addr >> SIZE) : '0;
  assign wr_row  = RW'(wr_addr >> (SIZE + BANK_S));
  assign rd_row  = RW'(rd_addr >> (SIZE + BANK_S));

  // A bank has one port, so a same-bank wr/rd pair is resolved by the priority pointer.
  assign conflict = wr_valid & rd_valid & (wr_bank == rd_bank);
  assign wr_ready = ~rst & ~(conflict & (prio == PRIO_RD));
  assign rd_ready = ~rst & credit & ~(conflict & (prio == PRIO_WR));
  assign wr_fire  = wr_valid & wr_ready;
  assign rd_fire  = rd_valid & rd_ready;

  // Round-robin: hand priority to the other channel after every collision.
  always_ff @(posedge clk) begin
    if (rst)           prio <= PRIO_WR;
    else if (conflict) prio <= (prio == PRIO_WR) ? PRIO_RD : PRIO_WR;
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DW-1:0] mem [ROWS];

    // Byte-strobed row write; contents survive reset.
    always_ff @(posedge clk) begin
      if (wr_fire && (wr_bank == BW'(b))) begin
        for (int i = 0; i < NB; i++) begin
          if (wr_strb[i]) mem[wr_row][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end

    assign bank_rdata[b] = mem[rd_row];

`ifdef MEM_BANK_PARITY_EN
    logic [NB-1:0] par [ROWS];
    logic          rerr;

    // Even parity per byte, written under the same strobe as the data byte.
    always_ff @(posedge clk) begin
      if (wr_fire && (wr_bank == BW'(b))) begin
        for (int i = 0; i < NB; i++) begin
          if (wr_strb[i]) par[wr_row][i] <= ^wr_data[8*i +: 8];
        end
      end
    end

    // Any byte whose recomputed parity disagrees flags the whole row.
    always_comb begin
      rerr = 1'b0;
      for (int i = 0; i < NB; i++) begin
        if ((^bank_rdata[b][8*i +: 8]) != par[rd_row][i]) rerr = 1'b1;
      end
    end

    assign bank_rerr[b] = rerr;
`else
    assign bank_rerr[b] = 1'b0;
`endif
  end

  assign rd_rdata = bank_rdata[rd_bank];
  assign rd_rerr  = bank_rerr[rd_bank];

  // The row is captured straight into the buffer at the accept edge, so nothing
  // is ever in flight outside it and buffer occupancy alone gives read credit.
  mem_rsp_fifo #(.DW(DW)) u_rsp_fifo (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (rd_fire),
    .s_tready (credit),
    .s_tdata  (rd_rdata),
    .s_tuser  (rd_rerr),
    .m_tvalid (rsp_valid),
    .m_tready (rsp_ready),
    .m_tdata  (rsp_data),
    .m_tuser  (fifo_err)
  );

  assign rsp_err = rsp_valid & fifo_err;

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// tb/tb_mem_bank_ctrl.sv - randomized self-checking bench for mem_bank_ctrl against a row-level model
module tb_mem_bank_ctrl;

  localparam int SIZE   = 7;
  localparam int ADDR_W = 12;
  localparam int NB     = 128;
  localparam int DW     = 1024;
  localparam int NROWS  = 32;
`ifdef MEM_BANK_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_valid = 1'b0, rd_valid = 1'b0, rsp_ready = 1'b0;
  logic              wr_ready, rd_ready, rsp_valid, rsp_err;
  logic [ADDR_W-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0]     wr_data = '0, rsp_data;
  logic [NB-1:0]     wr_strb = '0;

  always #5 clk = ~clk;

  mem_bank_ctrl #(.SIZE(SIZE), .ADDR_W(ADDR_W), .NUM_BANKS(2)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
  } rsp_t;

  int            checks = 0;
  int            errors = 0;
  int            acc_rd = 0;
  logic [DW-1:0] ref_mem  [NROWS];
  logic [NB-1:0] bad_byte [NROWS];
  rsp_t          exp_q [$];
  bit            rd_turn = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    int k;
    checks++;
    if (got !== exp) begin
      errors++;
      k = 0;
      for (int i = NB - 1; i >= 0; i--) if (got[8*i +: 8] !== exp[8*i +: 8]) k = i;
      $display("FAIL %s got %h exp %h (byte %0d got %h exp %h)", tag, got[63:0], exp[63:0],
               k, got[8*k +: 8], exp[8*k +: 8]);
    end
  endtask

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [NB-1:0] rand_strb();
    logic [NB-1:0] s;
    for (int i = 0; i < NB / 32; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  // One clock: predict readies/response from the model, compare, then advance the model.
  task automatic step();
    bit   conf, ewr, erd, wf, rf, pop;
    int   wrow, rrow;
    rsp_t r;
    @(negedge clk);
    wrow = int'(wr_addr) / NB;
    rrow = int'(rd_addr) / NB;
    conf = wr_valid && rd_valid && ((wrow % 2) == (rrow % 2));
    if (rst) begin
      ewr = 1'b0;
      erd = 1'b0;
    end else begin
      ewr = !(conf && rd_turn);
      erd = (exp_q.size() < 2) && !(conf && !rd_turn);
    end
    check("wr_ready", DW'(wr_ready), DW'(ewr));
    check("rd_ready", DW'(rd_ready), DW'(erd));
    if (!rst) begin
      check("rsp_valid", DW'(rsp_valid), DW'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("rsp_data", rsp_data, exp_q[0].data);
        check("rsp_err", DW'(rsp_err), DW'(exp_q[0].err));
      end
    end
    if (rd_valid && rd_ready) acc_rd++;
    wf  = wr_valid && ewr;
    rf  = rd_valid && erd;
    pop = !rst && (exp_q.size() != 0) && rsp_ready;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      rd_turn = 1'b0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (rf) begin
        r.data = ref_mem[rrow];
        r.err  = (bad_byte[rrow] != '0);
        exp_q.push_back(r);
      end
      if (wf) begin
        for (int i = 0; i < NB; i++) begin
          if (wr_strb[i]) begin
            ref_mem[wrow][8*i +: 8] = wr_data[8*i +: 8];
            bad_byte[wrow][i] = 1'b0;
          end
        end
      end
      if (conf) rd_turn = !rd_turn;
    end
    #1;
  endtask

  task automatic idle();
    wr_valid = 1'b0;
    rd_valid = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] expv;
    for (int r = 0; r < NROWS; r++) bad_byte[r] = '0;

    // Reset state
    step();
    step();
    rst = 1'b0;
    rsp_ready = 1'b1;

    // Fill every row so parity and data are defined everywhere
    for (int r = 0; r < NROWS; r++) begin
      wr_valid = 1'b1;
      wr_addr  = ADDR_W'(r * NB);
      wr_data  = rand_vec();
      wr_strb  = '1;
      step();
    end
    idle();

    // 1: byte i = i, read back next cycle
    for (int i = 0; i < NB; i++) expv[8*i +: 8] = 8'(i);
    wr_valid = 1'b1; wr_addr = 12'h000; wr_data = expv; wr_strb = '1;
    step();
    idle();
    rd_valid = 1'b1; rd_addr = 12'h000;
    step();
    idle();
    #1;
    check("t1_rsp_valid", DW'(rsp_valid), DW'(1'b1));
    check("t1_rsp_data", rsp_data, expv);
    check("t1_rsp_err", DW'(rsp_err), DW'(1'b0));
    step();

    // 2: single-byte strobe over a row of 0x55
    wr_valid = 1'b1; wr_addr = 12'h080; wr_data = {NB{8'h55}}; wr_strb = '1;
    step();
    wr_data = {NB{8'hAA}}; wr_strb = NB'(1);
    step();
    idle();
    rd_valid = 1'b1; rd_addr = 12'h080;
    step();
    idle();
    #1;
    expv = {{(NB-1){8'h55}}, 8'hAA};
    check("t2_row", rsp_data, expv);
    step();

    // 3: same-bank collision alternates, different banks proceed together
    wr_valid = 1'b1; wr_addr = 12'h000; wr_data = rand_vec(); wr_strb = '1;
    rd_valid = 1'b1; rd_addr = 12'h100;
    #1;
    check("t3_c1_wr", DW'(wr_ready), DW'(1'b1));
    check("t3_c1_rd", DW'(rd_ready), DW'(1'b0));
    step();
    #1;
    check("t3_c2_wr", DW'(wr_ready), DW'(1'b0));
    check("t3_c2_rd", DW'(rd_ready), DW'(1'b1));
    step();
    rd_addr = 12'h080;
    #1;
    check("t3_diff_wr", DW'(wr_ready), DW'(1'b1));
    check("t3_diff_rd", DW'(rd_ready), DW'(1'b1));
    step();
    idle();
    for (int i = 0; i < 3; i++) step();

    // 4: backpressure caps accepted reads at the buffer depth
    rsp_ready = 1'b0;
    acc_rd = 0;
    for (int i = 0; i < 5; i++) begin
      rd_valid = 1'b1;
      rd_addr  = ADDR_W'($urandom_range(NROWS - 1) * NB);
      step();
    end
    check("t4_accepted", DW'(acc_rd), DW'(2));
    idle();
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    rd_valid = 1'b1; rd_addr = 12'h100;
    #1;
    check("t4_resume", DW'(rd_ready), DW'(1'b1));
    step();
    idle();
    step();
    step();

    // 5: reset with two responses buffered
    rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd_valid = 1'b1;
      rd_addr  = ADDR_W'($urandom_range(NROWS - 1) * NB);
      step();
    end
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("t5_rsp_valid", DW'(rsp_valid), DW'(1'b0));
    rsp_ready = 1'b1;
    rd_valid = 1'b1; rd_addr = 12'h080;
    step();
    idle();
    step();
    step();

    // Randomized traffic with backpressure and occasional empty strobes
    for (int c = 0; c < 600; c++) begin
      rsp_ready = ($urandom_range(3) != 0);
      wr_valid  = $urandom_range(1);
      rd_valid  = $urandom_range(1);
      wr_addr   = ADDR_W'($urandom);
      rd_addr   = ADDR_W'($urandom);
      wr_data   = rand_vec();
      wr_strb   = ($urandom_range(7) == 0) ? '0 : rand_strb();
      step();
    end
    idle();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // 6: corrupt one stored bit of row 3 (bank 1)
`ifdef MEM_BANK_PARITY_EN
    dut.g_bank[1].mem[1][0] = ~dut.g_bank[1].mem[1][0];
    ref_mem[3][0] = ~ref_mem[3][0];
    bad_byte[3][0] = 1'b1;
`endif
    rd_valid = 1'b1; rd_addr = 12'h180;
    step();
    idle();
    #1;
    check("t6_rsp_err", DW'(rsp_err), DW'(PAR_ON));
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
